// File: rtl/neurochip_cfg_loader.sv
// Configuration chain loader: accepts bytes over a valid/ready handshake and
// shifts them MSB first into a serial chain of CHAIN_LEN bits, keeping a
// running CRC-8 of the shifted bits and flagging completion or starvation.
module neurochip_cfg_loader #(
    parameter int CHAIN_LEN = 256,
    parameter int TIMEOUT   = 1024
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic       abort_i,
    input  logic [7:0] in_data_i,
    input  logic       in_valid_i,
    output logic       in_ready_o,
    output logic       cfg_en_o,
    output logic       cfg_bit_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o,
    output logic [7:0] crc_o
);

    localparam int NUM_BYTES = CHAIN_LEN / 8;
    localparam int BIT_W     = $clog2(CHAIN_LEN + 1);
    localparam int BYTE_W    = $clog2(NUM_BYTES + 1);
    localparam logic [BIT_W-1:0]  LAST_BIT   = BIT_W'(CHAIN_LEN - 1);
    localparam logic [BYTE_W-1:0] BYTE_LIMIT = BYTE_W'(NUM_BYTES);
    localparam logic [15:0]       STARVE_MAX = 16'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, FETCH, SHIFT, DONE, ERR} state_e;

    state_e             state_q, state_d;
    logic [7:0]         hold_q, hold_d;
    logic               hold_vld_q, hold_vld_d;
    logic [7:0]         shift_q, shift_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic [15:0]        starve_q, starve_d;
    logic [7:0]         crc_q, crc_d;

    logic in_load;
    logic launch;
    logic kill;
    logic byte_end;
    logic last_bit;
    logic hold_drain;
    logic in_ready;
    logic handshake;
    logic starve_hit;

    // A load is active in FETCH/SHIFT; start only counts outside a load and
    // abort only inside one, so the two can never both take effect.
    assign in_load    = (state_q == FETCH) || (state_q == SHIFT);
    assign launch     = start_i && !in_load;
    assign kill       = abort_i && in_load;
    // Bytes are always whole, so the low three counter bits mark byte boundaries.
    assign byte_end   = (state_q == SHIFT) && (bit_cnt_q[2:0] == 3'b111);
    assign last_bit   = byte_end && (bit_cnt_q == LAST_BIT);
    // The holding byte leaves when FETCH hands it over or SHIFT reloads mid-stream,
    // which lets a new byte land in the same cycle.
    assign hold_drain = hold_vld_q && ((state_q == FETCH) || (byte_end && !last_bit));
    assign in_ready   = in_load && (!hold_vld_q || hold_drain) && (byte_cnt_q < BYTE_LIMIT);
    assign handshake  = in_valid_i && in_ready;
    assign starve_hit = (state_q == FETCH) && !hold_vld_q && !handshake && (starve_q == STARVE_MAX);

    // State register; reset drops straight to IDLE so every output clears at once.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection; abort beats every other transition while loading.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (start_i) state_d = FETCH;
            end
            FETCH: begin
                if (abort_i)         state_d = IDLE;
                else if (hold_vld_q) state_d = SHIFT;
                else if (starve_hit) state_d = ERR;
            end
            SHIFT: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else if (byte_end) begin
                    if (last_bit)        state_d = DONE;
                    else if (hold_vld_q) state_d = SHIFT;
                    else                 state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: holding byte, shifter, counters and CRC.
    always_comb begin
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        starve_d   = starve_q;
        crc_d      = crc_q;
        if (launch) begin
            hold_vld_d = 1'b0;
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
            starve_d   = '0;
            crc_d      = 8'h00;
        end else if (kill) begin
            hold_vld_d = 1'b0;
        end else begin
            if (state_q == SHIFT) begin
                shift_d   = {shift_q[6:0], 1'b0};
                bit_cnt_d = bit_cnt_q + 1'b1;
                crc_d     = {crc_q[6:0], 1'b0} ^ ((crc_q[7] ^ shift_q[7]) ? 8'h07 : 8'h00);
            end
            if (hold_drain) begin
                shift_d    = hold_q;
                hold_vld_d = 1'b0;
            end
            if (handshake) begin
                hold_d     = in_data_i;
                hold_vld_d = 1'b1;
                byte_cnt_d = byte_cnt_q + 1'b1;
                starve_d   = '0;
            end else if ((state_q == FETCH) && !hold_vld_q) begin
                starve_d = starve_q + 1'b1;
            end
        end
    end

    // Datapath registers, all cleared by reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_q     <= 8'h00;
            hold_vld_q <= 1'b0;
            shift_q    <= 8'h00;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            starve_q   <= '0;
            crc_q      <= 8'h00;
        end else begin
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            starve_q   <= starve_d;
            crc_q      <= crc_d;
        end
    end

    // Outputs decode from the current state so the chain only sees data in SHIFT.
    always_comb begin
        in_ready_o = in_ready;
        cfg_en_o   = (state_q == SHIFT);
        cfg_bit_o  = (state_q == SHIFT) && shift_q[7];
        busy_o     = in_load;
        done_o     = (state_q == DONE);
        err_o      = (state_q == ERR);
        crc_o      = crc_q;
    end

endmodule

// File: tb/tb_neurochip_cfg_loader.sv
// Bench for neurochip_cfg_loader: a 16-bit chain with a generous timeout
// and a second copy with a 4-cycle timeout for starvation behaviour.
module tb_neurochip_cfg_loader;

    logic       clk = 1'b0;
    logic       rstN = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] inData = 8'h00;
    logic       inValid = 1'b0;

    logic       inReady, cfgEn, cfgBit, busy, done, err;
    logic [7:0] crc;
    logic       inReadyT, cfgEnT, cfgBitT, busyT, doneT, errT;
    logic [7:0] crcT;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hsCount = 0;
    int enCountT = 0;
    int doneCyc = -1;
    bit doneLast = 1'b0;
    bit bitsQ[$];
    int enCyc[$];

    neurochip_cfg_loader #(.CHAIN_LEN(16), .TIMEOUT(64)) dut (
        .clk_i(clk), .rst_ni(rstN), .start_i(start), .abort_i(abort),
        .in_data_i(inData), .in_valid_i(inValid), .in_ready_o(inReady),
        .cfg_en_o(cfgEn), .cfg_bit_o(cfgBit), .busy_o(busy), .done_o(done),
        .err_o(err), .crc_o(crc)
    );

    neurochip_cfg_loader #(.CHAIN_LEN(16), .TIMEOUT(4)) dutT (
        .clk_i(clk), .rst_ni(rstN), .start_i(start), .abort_i(abort),
        .in_data_i(inData), .in_valid_i(inValid), .in_ready_o(inReadyT),
        .cfg_en_o(cfgEnT), .cfg_bit_o(cfgBitT), .busy_o(busyT), .done_o(doneT),
        .err_o(errT), .crc_o(crcT)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial forever #5 clk = ~clk;

    // Watch the chain side mid-cycle: record every enabled bit, handshakes and done rising.
    always @(negedge clk) begin
        #3;
        cyc++;
        if (cfgEn) begin
            bitsQ.push_back(cfgBit);
            enCyc.push_back(cyc);
        end
        if (cfgEnT) enCountT++;
        if (inValid && inReady) hsCount++;
        if (done && !doneLast) doneCyc = cyc;
        doneLast = done;
    end

    // Hard stop in case something wedges the sequence.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference CRC-8 (poly 0x07) over a 16-bit stream, MSB first.
    function automatic logic [7:0] crcModel(input logic [15:0] w);
        int c;
        c = 0;
        for (int i = 15; i >= 0; i--) begin
            if (((c / 128) % 2) != int'(w[i])) c = ((c * 2) % 256) ^ 7;
            else                                c = (c * 2) % 256;
        end
        return 8'(c);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic a);
        start = s;
        abort = a;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] b);
        int n;
        n = 0;
        inData  = b;
        inValid = 1'b1;
        while (!inReady && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("send_ready", 32'(inReady), 32'd1);
        @(negedge clk);
    endtask

    // One full load of two bytes, then compare the chain stream against the model.
    task automatic runLoad(input logic [7:0] b0, input logic [7:0] b1, input int gap0,
                           input int gap1, input bit offerExtra, input bit midStart,
                           input int expContig, input string tag);
        int base, hs0, n, last;
        logic [15:0] expWord, obsWord;
        base    = bitsQ.size();
        hs0     = hsCount;
        expWord = {b0, b1};
        obsWord = '0;
        applyStimulus(1'b1, 1'b0);
        inValid = 1'b0;
        repeat (gap0) @(negedge clk);
        sendByte(b0);
        inValid = 1'b0;
        repeat (gap1) @(negedge clk);
        sendByte(b1);
        if (offerExtra) begin
            inData  = 8'h5A;
            inValid = 1'b1;
        end else begin
            inValid = 1'b0;
        end
        if (midStart) applyStimulus(1'b1, 1'b0);
        n = 0;
        while (!done && !err && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_done"}, 32'(done), 32'd1);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_err"}, 32'(err), 32'd0);
        checkOutput({tag, "_ready"}, 32'(inReady), 32'd0);
        inValid = 1'b0;
        @(negedge clk);
        checkOutput({tag, "_encount"}, 32'(bitsQ.size() - base), 32'd16);
        for (int i = 0; i < 16; i++) begin
            if (base + i < bitsQ.size()) obsWord[15-i] = bitsQ[base+i];
        end
        checkOutput({tag, "_bits"}, 32'(obsWord), 32'(expWord));
        checkOutput({tag, "_crc"}, 32'(crc), 32'(crcModel(expWord)));
        checkOutput({tag, "_handshakes"}, 32'(hsCount - hs0), 32'd2);
        if (bitsQ.size() > base) begin
            last = enCyc.size() - 1;
            checkOutput({tag, "_done_next"}, 32'(doneCyc - enCyc[last]), 32'd1);
            if (expContig >= 0)
                checkOutput({tag, "_contig"}, 32'((enCyc[last] - enCyc[base]) == 15), 32'(expContig));
        end
    endtask

    initial begin
        int base, n, seen, baseT, gA, gB;
        logic [7:0] rA, rB;

        // Asynchronous reset: outputs must clear without a clock edge.
        #2 rstN = 1'b0;
        #1;
        checkOutput("rst_ready", 32'(inReady), 32'd0);
        checkOutput("rst_en", 32'(cfgEn), 32'd0);
        checkOutput("rst_bit", 32'(cfgBit), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_crc", 32'(crc), 32'd0);
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);

        // Back-to-back bytes with valid held high.
        runLoad(8'hA5, 8'h3C, 0, 0, 1'b0, 1'b0, 1, "basic");
        checkOutput("basic_crc_const", 32'(crc), 32'hED);

        // Second byte late enough to leave a gap in the enable stream.
        runLoad(8'hA5, 8'h3C, 0, 13, 1'b0, 1'b0, 0, "gap");
        checkOutput("gap_crc_const", 32'(crc), 32'hED);

        // Abort on the third shifting cycle.
        base = bitsQ.size();
        applyStimulus(1'b1, 1'b0);
        sendByte(8'hA5);
        inValid = 1'b0;
        seen = 0;
        n = 0;
        while (n < 50) begin
            if (cfgEn) seen++;
            if (seen == 3) break;
            @(negedge clk);
            n++;
        end
        checkOutput("abort_reach", 32'(seen), 32'd3);
        applyStimulus(1'b0, 1'b1);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_en", 32'(cfgEn), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_err", 32'(err), 32'd0);
        @(negedge clk);
        checkOutput("abort_encount", 32'(bitsQ.size() - base), 32'd3);
        if (bitsQ.size() >= base + 3)
            checkOutput("abort_bits", 32'({bitsQ[base], bitsQ[base+1], bitsQ[base+2]}), 32'b101);
        runLoad(8'h3C, 8'hC3, 0, 0, 1'b0, 1'b0, 1, "reload");

        // start and abort together in IDLE: start wins; abort alone then cancels.
        applyStimulus(1'b1, 1'b1);
        checkOutput("startwin_busy", 32'(busy), 32'd1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("abortwin_busy", 32'(busy), 32'd0);

        // A restart mid-load is ignored and a third offered byte is never taken.
        runLoad(8'h96, 8'h0F, 0, 0, 1'b1, 1'b1, 1, "extra");

        // Reset pulse in the middle of shifting.
        applyStimulus(1'b1, 1'b0);
        sendByte(8'h5A);
        sendByte(8'hC3);
        inValid = 1'b0;
        n = 0;
        while (!cfgEn && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        checkOutput("mid_shifting", 32'(cfgEn), 32'd1);
        rstN = 1'b0;
        #1;
        checkOutput("midrst_ready", 32'(inReady), 32'd0);
        checkOutput("midrst_en", 32'(cfgEn), 32'd0);
        checkOutput("midrst_bit", 32'(cfgBit), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_done", 32'(done), 32'd0);
        checkOutput("midrst_err", 32'(err), 32'd0);
        checkOutput("midrst_crc", 32'(crc), 32'd0);
        base = bitsQ.size();
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("midrst_noshift", 32'(bitsQ.size() - base), 32'd0);
        checkOutput("midrst_idle", 32'(busy), 32'd0);
        runLoad(8'h81, 8'h7E, 0, 0, 1'b0, 1'b0, 1, "postrst");

        // Starvation on the short-timeout copy.
        rstN = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        baseT = enCountT;
        applyStimulus(1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            checkOutput("to_busy", 32'(busyT), 32'd1);
            checkOutput("to_noerr", 32'(errT), 32'd0);
            @(negedge clk);
        end
        checkOutput("to_err", 32'(errT), 32'd1);
        checkOutput("to_idle", 32'(busyT), 32'd0);
        checkOutput("to_noen", 32'(enCountT - baseT), 32'd0);
        checkOutput("to_main_busy", 32'(busy), 32'd1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("to_abort_ignored", 32'(errT), 32'd1);
        checkOutput("to_main_aborted", 32'(busy), 32'd0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("to_restart_clr", 32'(errT), 32'd0);
        checkOutput("to_restart_busy", 32'(busyT), 32'd1);
        applyStimulus(1'b0, 1'b1);

        // Random bytes and random gaps well inside the main timeout.
        for (int r = 0; r < 4; r++) begin
            rA = 8'($urandom);
            rB = 8'($urandom);
            gA = int'($urandom_range(0, 6));
            gB = int'($urandom_range(0, 6));
            runLoad(rA, rB, gA, gB, 1'b0, 1'b0, -1, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
